// File: rtl/ptw_sched_pkg.sv
// ptw_sched_pkg: shared types and helpers for the PTW memory-port scheduler.
//   state_t   : scheduler FSM encoding (logic [2:0])
//   PTE_*     : bit positions of the valid / accessed / dirty bits in a PTE
//   pte_merge : accessed/dirty merge applied during the mark read-modify-write
package ptw_sched_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WALK_REQ     = 3'd1,
    WALK_WAIT    = 3'd2,
    MARK_RD      = 3'd3,
    MARK_RD_WAIT = 3'd4,
    MARK_WR      = 3'd5,
    MARK_WR_WAIT = 3'd6,
    DONE         = 3'd7
  } state_t;

  localparam int PTE_V = 0;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  // Setting D implies setting A, so a dirty mark always leaves both bits set.
  function automatic logic [63:0] pte_merge(input logic [63:0] pte,
                                            input logic        set_a,
                                            input logic        set_d);
    logic [63:0] res;
    res        = pte;
    res[PTE_A] = pte[PTE_A] | set_a | set_d;
    res[PTE_D] = pte[PTE_D] | set_d;
    return res;
  endfunction

endpackage

// File: rtl/ptw_sched_mem.sv
// ptw_sched_mem: pending-request latches, scheduler FSM and accessed/dirty
// read-modify-write for the shared 64-bit PTE memory port.
//   walk_req_* / walk_rsp_*  : walker read request pulse and response pulse
//   mark_*   / mark_rsp_valid: A/D mark request pulse and completion pulse
//   mem_req_* / mem_rsp_*    : single-outstanding memory port
//   busy                     : FSM active or a request pending
//   skip_evt                 : (PTW_SCHED_PERF_EN only) mark finished without store
module ptw_sched_mem
  import ptw_sched_pkg::*;
#(
  parameter int PA_W = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            walk_req_valid,
  input  logic [PA_W-1:0] walk_req_addr,
  output logic            walk_rsp_valid,
  output logic [63:0]     walk_rsp_data,
  input  logic            mark_valid,
  input  logic            mark_accessed,
  input  logic            mark_dirty,
  input  logic [63:0]     mark_addr,
  output logic            mark_rsp_valid,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [PA_W-1:0] mem_req_addr,
  output logic            mem_req_store,
  output logic [63:0]     mem_req_data,
  input  logic            mem_rsp_valid,
  input  logic [63:0]     mem_rsp_data,
  output logic            busy
`ifdef PTW_SCHED_PERF_EN
  ,
  output logic            skip_evt
`endif
);

  state_t          state_r, state_s;
  logic            walk_pend_r, walk_pend_s, mark_pend_r, mark_pend_s;
  logic [PA_W-1:0] walk_addr_r, mark_addr_r, cur_addr_r, cur_addr_s;
  logic            mark_a_r, mark_d_r, cur_a_r, cur_a_s, cur_d_r, cur_d_s;
  logic            req_valid_r, req_valid_s, req_store_r, req_store_s;
  logic [PA_W-1:0] req_addr_r, req_addr_s;
  logic [63:0]     req_data_r, req_data_s, merged_s;
  logic            walk_rsp_valid_r, walk_rsp_valid_s, mark_rsp_valid_r, mark_rsp_valid_s;
  logic [63:0]     walk_rsp_data_r, walk_rsp_data_s;
  logic            busy_r, busy_s, skip_r, skip_s;
  logic            mark_take_s, walk_take_s;
  logic [PA_W-1:0] mark_sel_addr_s, walk_sel_addr_s;
  logic            mark_sel_a_s, mark_sel_d_s;
  logic            unused_s;

  // Address bits above PA_W and the byte offset within the PTE are not used.
  assign unused_s = ^{mark_addr[63:PA_W], mark_addr[2:0], walk_req_addr[2:0]};

  // Bypass: a request arriving this cycle is used directly when nothing is latched.
  assign mark_sel_addr_s = mark_pend_r ? mark_addr_r : {mark_addr[PA_W-1:3], 3'b000};
  assign mark_sel_a_s    = mark_pend_r ? mark_a_r    : mark_accessed;
  assign mark_sel_d_s    = mark_pend_r ? mark_d_r    : mark_dirty;
  assign walk_sel_addr_s = walk_pend_r ? walk_addr_r : {walk_req_addr[PA_W-1:3], 3'b000};
  assign merged_s        = pte_merge(mem_rsp_data, cur_a_r, cur_d_r);

  // Next-state, memory-request and response decode.
  always_comb begin
    state_s          = state_r;
    req_valid_s      = req_valid_r;
    req_addr_s       = req_addr_r;
    req_store_s      = req_store_r;
    req_data_s       = req_data_r;
    cur_addr_s       = cur_addr_r;
    cur_a_s          = cur_a_r;
    cur_d_s          = cur_d_r;
    walk_rsp_valid_s = 1'b0;
    walk_rsp_data_s  = walk_rsp_data_r;
    skip_s           = 1'b0;
    mark_take_s      = 1'b0;
    walk_take_s      = 1'b0;
    // An accepted request is dropped and its fields return to zero.
    if (req_valid_r && mem_req_ready) begin
      req_valid_s = 1'b0;
      req_addr_s  = {PA_W{1'b0}};
      req_store_s = 1'b0;
      req_data_s  = 64'd0;
    end else begin
      req_valid_s = req_valid_r;
    end
    case (state_r)
      IDLE: begin
        if (mark_pend_r || mark_valid) begin
          mark_take_s = 1'b1;
          state_s     = MARK_RD;
          req_valid_s = 1'b1;
          req_addr_s  = mark_sel_addr_s;
          req_store_s = 1'b0;
          req_data_s  = 64'd0;
          cur_addr_s  = mark_sel_addr_s;
          cur_a_s     = mark_sel_a_s;
          cur_d_s     = mark_sel_d_s;
        end else if (walk_pend_r || walk_req_valid) begin
          walk_take_s = 1'b1;
          state_s     = WALK_REQ;
          req_valid_s = 1'b1;
          req_addr_s  = walk_sel_addr_s;
          req_store_s = 1'b0;
          req_data_s  = 64'd0;
        end else begin
          state_s = IDLE;
        end
      end
      WALK_REQ:     if (mem_req_ready) state_s = WALK_WAIT;    else state_s = WALK_REQ;
      MARK_RD:      if (mem_req_ready) state_s = MARK_RD_WAIT; else state_s = MARK_RD;
      MARK_WR:      if (mem_req_ready) state_s = MARK_WR_WAIT; else state_s = MARK_WR;
      WALK_WAIT: begin
        if (mem_rsp_valid) begin
          walk_rsp_valid_s = 1'b1;
          walk_rsp_data_s  = mem_rsp_data;
          state_s          = IDLE;
        end else begin
          state_s = WALK_WAIT;
        end
      end
      MARK_RD_WAIT: begin
        if (!mem_rsp_valid) begin
          state_s = MARK_RD_WAIT;
        end else if (!mem_rsp_data[PTE_V] || merged_s == mem_rsp_data) begin
          // Invalid PTE or bits already set: nothing to write back.
          state_s = DONE;
          skip_s  = 1'b1;
        end else begin
          state_s     = MARK_WR;
          req_valid_s = 1'b1;
          req_addr_s  = cur_addr_r;
          req_store_s = 1'b1;
          req_data_s  = merged_s;
        end
      end
      MARK_WR_WAIT: if (mem_rsp_valid) state_s = DONE; else state_s = MARK_WR_WAIT;
      DONE:         state_s = IDLE;
      default:      state_s = IDLE;
    endcase
    mark_rsp_valid_s = (state_s == DONE);
  end

  // Pending flags: set by a pulse, cleared when the FSM takes the request.
  always_comb begin
    if (mark_take_s) mark_pend_s = 1'b0;
    else             mark_pend_s = mark_pend_r | mark_valid;
    if (walk_take_s) walk_pend_s = 1'b0;
    else             walk_pend_s = walk_pend_r | walk_req_valid;
    busy_s = (state_s != IDLE) | mark_pend_s | walk_pend_s;
  end

  // State, latches and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= IDLE;
      walk_pend_r      <= 1'b0;
      mark_pend_r      <= 1'b0;
      walk_addr_r      <= {PA_W{1'b0}};
      mark_addr_r      <= {PA_W{1'b0}};
      mark_a_r         <= 1'b0;
      mark_d_r         <= 1'b0;
      cur_addr_r       <= {PA_W{1'b0}};
      cur_a_r          <= 1'b0;
      cur_d_r          <= 1'b0;
      req_valid_r      <= 1'b0;
      req_addr_r       <= {PA_W{1'b0}};
      req_store_r      <= 1'b0;
      req_data_r       <= 64'd0;
      walk_rsp_valid_r <= 1'b0;
      walk_rsp_data_r  <= 64'd0;
      mark_rsp_valid_r <= 1'b0;
      busy_r           <= 1'b0;
      skip_r           <= 1'b0;
    end else begin
      state_r          <= state_s;
      walk_pend_r      <= walk_pend_s;
      mark_pend_r      <= mark_pend_s;
      if (walk_req_valid && !walk_pend_r) walk_addr_r <= {walk_req_addr[PA_W-1:3], 3'b000};
      if (mark_valid && !mark_pend_r) begin
        mark_addr_r <= {mark_addr[PA_W-1:3], 3'b000};
        mark_a_r    <= mark_accessed;
        mark_d_r    <= mark_dirty;
      end
      cur_addr_r       <= cur_addr_s;
      cur_a_r          <= cur_a_s;
      cur_d_r          <= cur_d_s;
      req_valid_r      <= req_valid_s;
      req_addr_r       <= req_addr_s;
      req_store_r      <= req_store_s;
      req_data_r       <= req_data_s;
      walk_rsp_valid_r <= walk_rsp_valid_s;
      walk_rsp_data_r  <= walk_rsp_data_s;
      mark_rsp_valid_r <= mark_rsp_valid_s;
      busy_r           <= busy_s;
      skip_r           <= skip_s;
    end
  end

  assign walk_rsp_valid = walk_rsp_valid_r;
  assign walk_rsp_data  = walk_rsp_data_r;
  assign mark_rsp_valid = mark_rsp_valid_r;
  assign mem_req_valid  = req_valid_r;
  assign mem_req_addr   = req_addr_r;
  assign mem_req_store  = req_store_r;
  assign mem_req_data   = req_data_r;
  assign busy           = busy_r;
`ifdef PTW_SCHED_PERF_EN
  assign skip_evt = skip_r;
`endif

endmodule

// File: rtl/ptw_sched_perf.sv
// ptw_sched_perf: saturating event counters for the PTW memory scheduler.
// Only exists when PTW_SCHED_PERF_EN is defined.
//   clk, reset_n                     : clock, async active-low reset
//   walk_evt / mark_evt / skip_evt   : single-cycle event pulses
//   walk_cnt / mark_cnt / skip_cnt   : CNT_W-bit counters, stick at all-ones
`ifdef PTW_SCHED_PERF_EN
module ptw_sched_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             walk_evt,
  input  logic             mark_evt,
  input  logic             skip_evt,
  output logic [CNT_W-1:0] walk_cnt,
  output logic [CNT_W-1:0] mark_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] walk_cnt_r, mark_cnt_r, skip_cnt_r;

  // Counter bank: increment on event, saturate at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      walk_cnt_r <= {CNT_W{1'b0}};
      mark_cnt_r <= {CNT_W{1'b0}};
      skip_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (walk_evt && walk_cnt_r != CNT_MAX) walk_cnt_r <= walk_cnt_r + CNT_ONE;
      if (mark_evt && mark_cnt_r != CNT_MAX) mark_cnt_r <= mark_cnt_r + CNT_ONE;
      if (skip_evt && skip_cnt_r != CNT_MAX) skip_cnt_r <= skip_cnt_r + CNT_ONE;
    end
  end

  assign walk_cnt = walk_cnt_r;
  assign mark_cnt = mark_cnt_r;
  assign skip_cnt = skip_cnt_r;

endmodule
`endif

// File: rtl/ptw_mem_sched.sv
// ptw_mem_sched: memory-port scheduler for the page-table walker. Shares one
// 64-bit PTE port between walk reads and accessed/dirty marks; marks are
// executed as atomic read-modify-writes (mark > walk priority).
// Optional feature macro: PTW_SCHED_PERF_EN enables the perf counter bank;
// without it perf_* are tied to zero.
// Ports: clk, reset_n (async active-low); walk_req_*/walk_rsp_*; mark_*/
// mark_rsp_valid; mem_req_*/mem_rsp_*; busy; perf_walk/mark/wskip_cnt.
module ptw_mem_sched
  import ptw_sched_pkg::*;
#(
  parameter int PA_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             walk_req_valid,
  input  logic [PA_W-1:0]  walk_req_addr,
  output logic             walk_rsp_valid,
  output logic [63:0]      walk_rsp_data,
  input  logic             mark_valid,
  input  logic             mark_accessed,
  input  logic             mark_dirty,
  input  logic [63:0]      mark_addr,
  output logic             mark_rsp_valid,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [PA_W-1:0]  mem_req_addr,
  output logic             mem_req_store,
  output logic [63:0]      mem_req_data,
  input  logic             mem_rsp_valid,
  input  logic [63:0]      mem_rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] perf_walk_cnt,
  output logic [CNT_W-1:0] perf_mark_cnt,
  output logic [CNT_W-1:0] perf_wskip_cnt
);

`ifdef PTW_SCHED_PERF_EN
  logic skip_evt;
`endif

  ptw_sched_mem #(.PA_W(PA_W)) u_mem (
    .clk            (clk),
    .reset_n        (reset_n),
    .walk_req_valid (walk_req_valid),
    .walk_req_addr  (walk_req_addr),
    .walk_rsp_valid (walk_rsp_valid),
    .walk_rsp_data  (walk_rsp_data),
    .mark_valid     (mark_valid),
    .mark_accessed  (mark_accessed),
    .mark_dirty     (mark_dirty),
    .mark_addr      (mark_addr),
    .mark_rsp_valid (mark_rsp_valid),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_store  (mem_req_store),
    .mem_req_data   (mem_req_data),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .busy           (busy)
`ifdef PTW_SCHED_PERF_EN
    ,
    .skip_evt       (skip_evt)
`endif
  );

`ifdef PTW_SCHED_PERF_EN
  ptw_sched_perf #(.CNT_W(CNT_W)) u_perf (
    .clk      (clk),
    .reset_n  (reset_n),
    .walk_evt (walk_rsp_valid),
    .mark_evt (mark_rsp_valid),
    .skip_evt (skip_evt),
    .walk_cnt (perf_walk_cnt),
    .mark_cnt (perf_mark_cnt),
    .skip_cnt (perf_wskip_cnt)
  );
`else
  assign perf_walk_cnt  = {CNT_W{1'b0}};
  assign perf_mark_cnt  = {CNT_W{1'b0}};
  assign perf_wskip_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ptw_mem_sched.sv
// tb_ptw_mem_sched: directed self-checking bench for ptw_mem_sched.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_ptw_mem_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        walk_req_valid = 1'b0;
  logic [31:0] walk_req_addr = 32'd0;
  logic        walk_rsp_valid;
  logic [63:0] walk_rsp_data;
  logic        mark_valid = 1'b0, mark_accessed = 1'b0, mark_dirty = 1'b0;
  logic [63:0] mark_addr = 64'd0;
  logic        mark_rsp_valid;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_req_store;
  logic [63:0] mem_req_data;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_data = 64'd0;
  logic        busy;
  logic [31:0] perf_walk_cnt, perf_mark_cnt, perf_wskip_cnt;

  int n_cmp = 0;
  int n_err = 0;

  ptw_mem_sched #(.PA_W(32), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .walk_req_valid(walk_req_valid), .walk_req_addr(walk_req_addr),
    .walk_rsp_valid(walk_rsp_valid), .walk_rsp_data(walk_rsp_data),
    .mark_valid(mark_valid), .mark_accessed(mark_accessed), .mark_dirty(mark_dirty),
    .mark_addr(mark_addr), .mark_rsp_valid(mark_rsp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_store(mem_req_store), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .busy(busy),
    .perf_walk_cnt(perf_walk_cnt), .perf_mark_cnt(perf_mark_cnt), .perf_wskip_cnt(perf_wskip_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a request, check its fields, let it be accepted.
  task automatic take_req(input string tag, input logic [31:0] addr,
                          input logic st, input logic [63:0] data);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {63'd0, mem_req_valid}, 64'd1);
    check({tag, "_addr"},  {32'd0, mem_req_addr},  {32'd0, addr});
    check({tag, "_store"}, {63'd0, mem_req_store}, {63'd0, st});
    check({tag, "_data"},  mem_req_data, data);
    tick();
    check({tag, "_drop"},  {63'd0, mem_req_valid}, 64'd0);
  endtask

  task automatic give_rsp(input logic [63:0] data, input int lat);
    repeat (lat) tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = data;
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 64'd0;
  endtask

  task automatic check_perf(input string tag, input int w, input int m, input int s);
`ifdef PTW_SCHED_PERF_EN
    check({tag, "_pwalk"}, {32'd0, perf_walk_cnt},  64'(w));
    check({tag, "_pmark"}, {32'd0, perf_mark_cnt},  64'(m));
    check({tag, "_pskip"}, {32'd0, perf_wskip_cnt}, 64'(s));
`else
    check({tag, "_pwalk"}, {32'd0, perf_walk_cnt},  64'd0);
    check({tag, "_pmark"}, {32'd0, perf_mark_cnt},  64'd0);
    check({tag, "_pskip"}, {32'd0, perf_wskip_cnt}, 64'd0);
    if (w + m + s < 0) $display("unreachable");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_reqv", {63'd0, mem_req_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_wrsp", {63'd0, walk_rsp_valid}, 64'd0);
    check("rst_mrsp", {63'd0, mark_rsp_valid}, 64'd0);
    check_perf("rst", 0, 0, 0);
    reset_n = 1'b1;
    tick();

    // 1: walk read, request issues the cycle after the pulse
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_1008;
    tick();
    walk_req_valid = 1'b0;
    check("t1_issue", {63'd0, mem_req_valid}, 64'd1);
    check("t1_busy", {63'd0, busy}, 64'd1);
    take_req("t1", 32'h8000_1008, 1'b0, 64'd0);
    give_rsp(64'h2000_0C01, 2);
    check("t1_wrspv", {63'd0, walk_rsp_valid}, 64'd1);
    check("t1_wrspd", walk_rsp_data, 64'h2000_0C01);
    tick();
    check("t1_wrsp_pulse", {63'd0, walk_rsp_valid}, 64'd0);
    check("t1_idle", {63'd0, busy}, 64'd0);

    // 2: mark A, PTE 0x0F -> store 0x4F; upper/low address bits dropped
    mark_valid = 1'b1; mark_accessed = 1'b1; mark_dirty = 1'b0;
    mark_addr = 64'hFFFF_FFFF_8000_2013;
    tick();
    mark_valid = 1'b0;
    take_req("t2rd", 32'h8000_2010, 1'b0, 64'd0);
    give_rsp(64'h0F, 1);
    check("t2_early_mrsp", {63'd0, mark_rsp_valid}, 64'd0);
    take_req("t2wr", 32'h8000_2010, 1'b1, 64'h4F);
    give_rsp(64'd0, 1);
    check("t2_mrsp", {63'd0, mark_rsp_valid}, 64'd1);
    tick();
    check("t2_mrsp_pulse", {63'd0, mark_rsp_valid}, 64'd0);

    // 3: mark D, PTE 0xCF already has A and D -> no store
    mark_valid = 1'b1; mark_accessed = 1'b0; mark_dirty = 1'b1;
    mark_addr = 64'h8000_3018;
    tick();
    mark_valid = 1'b0;
    take_req("t3rd", 32'h8000_3018, 1'b0, 64'd0);
    give_rsp(64'hCF, 0);
    check("t3_mrsp", {63'd0, mark_rsp_valid}, 64'd1);
    check("t3_nostore", {63'd0, mem_req_valid}, 64'd0);
    tick();

    // 3b: mark A on an invalid PTE (V=0) -> no store
    mark_valid = 1'b1; mark_accessed = 1'b1; mark_dirty = 1'b0;
    mark_addr = 64'h8000_3020;
    tick();
    mark_valid = 1'b0;
    take_req("t3brd", 32'h8000_3020, 1'b0, 64'd0);
    give_rsp(64'h0E, 0);
    check("t3b_mrsp", {63'd0, mark_rsp_valid}, 64'd1);
    check("t3b_nostore", {63'd0, mem_req_valid}, 64'd0);
    tick();

    // 4: simultaneous walk and mark: mark RMW first, then the walk
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_4000;
    mark_valid = 1'b1; mark_accessed = 1'b1; mark_dirty = 1'b1;
    mark_addr = 64'h8000_5008;
    tick();
    walk_req_valid = 1'b0; mark_valid = 1'b0;
    take_req("t4rd", 32'h8000_5008, 1'b0, 64'd0);
    give_rsp(64'h01, 0);
    take_req("t4wr", 32'h8000_5008, 1'b1, 64'hC1);
    give_rsp(64'd0, 0);
    check("t4_mrsp", {63'd0, mark_rsp_valid}, 64'd1);
    check("t4_wrsp_not_yet", {63'd0, walk_rsp_valid}, 64'd0);
    check("t4_busy", {63'd0, busy}, 64'd1);
    take_req("t4w", 32'h8000_4000, 1'b0, 64'd0);
    give_rsp(64'h1234_5678_9ABC_DEF1, 0);
    check("t4_wrspv", {63'd0, walk_rsp_valid}, 64'd1);
    check("t4_wrspd", walk_rsp_data, 64'h1234_5678_9ABC_DEF1);
    tick();

    // 5: ready low for 5 cycles; a mark pulse arrives during the stall
    mem_req_ready = 1'b0;
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_6010;
    tick();
    walk_req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_v", {63'd0, mem_req_valid}, 64'd1);
      check("t5_hold_a", {32'd0, mem_req_addr}, 64'h8000_6010);
      check("t5_hold_s", {63'd0, mem_req_store}, 64'd0);
      if (i == 1) begin
        mark_valid = 1'b1; mark_accessed = 1'b1; mark_dirty = 1'b0;
        mark_addr = 64'h8000_7000;
      end else begin
        mark_valid = 1'b0;
      end
      tick();
    end
    mark_valid = 1'b0;
    mem_req_ready = 1'b1;
    take_req("t5w", 32'h8000_6010, 1'b0, 64'd0);
    give_rsp(64'hAAAA_0001, 1);
    check("t5_wrspd", walk_rsp_data, 64'hAAAA_0001);
    take_req("t5rd", 32'h8000_7000, 1'b0, 64'd0);
    give_rsp(64'h41, 0);
    check("t5_mrsp", {63'd0, mark_rsp_valid}, 64'd1);
    tick();
    tick();
    check("t5_idle", {63'd0, busy}, 64'd0);
    check_perf("mid", 3, 5, 3);

    // 6: reset during MARK_WR_WAIT
    mark_valid = 1'b1; mark_accessed = 1'b1; mark_dirty = 1'b0;
    mark_addr = 64'h8000_8000;
    tick();
    mark_valid = 1'b0;
    take_req("t6rd", 32'h8000_8000, 1'b0, 64'd0);
    give_rsp(64'h01, 0);
    take_req("t6wr", 32'h8000_8000, 1'b1, 64'h41);
    check("t6_busy_pre", {63'd0, busy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_busy", {63'd0, busy}, 64'd0);
    check("t6_async_reqv", {63'd0, mem_req_valid}, 64'd0);
    check("t6_async_mrsp", {63'd0, mark_rsp_valid}, 64'd0);
    check_perf("t6rst", 0, 0, 0);
    tick();
    reset_n = 1'b1;
    give_rsp(64'hDEAD, 0);
    check("t6_late_wrsp", {63'd0, walk_rsp_valid}, 64'd0);
    check("t6_late_mrsp", {63'd0, mark_rsp_valid}, 64'd0);
    check("t6_late_reqv", {63'd0, mem_req_valid}, 64'd0);
    tick();
    check("t6_late_busy", {63'd0, busy}, 64'd0);
    walk_req_valid = 1'b1; walk_req_addr = 32'h8000_9008;
    tick();
    walk_req_valid = 1'b0;
    take_req("t6w", 32'h8000_9008, 1'b0, 64'd0);
    give_rsp(64'h5555_0001, 1);
    check("t6_wrspv", {63'd0, walk_rsp_valid}, 64'd1);
    check("t6_wrspd", walk_rsp_data, 64'h5555_0001);
    tick();
    check_perf("end", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
